// File: rtl/cpu_ifetch_pkg.sv
// cpu_ifetch_pkg
//   Shared CPU definitions used by the instruction-fetch responder:
//   fetch state encoding and the instruction word presented on bubbles.
package cpu_ifetch_pkg;

  typedef enum logic [1:0] {
    IFETCH_IDLE    = 2'd0,  // nothing outstanding on imem
    IFETCH_WAIT    = 2'd1,  // one accepted request, response pending
    IFETCH_DISCARD = 2'd2   // pending response belongs to a flushed path
  } ifetch_state_e;

  // Word driven on p2_instr whenever p2 has no valid instruction.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/cpu_ifetch.sv
// cpu_ifetch
//   Instruction-fetch responder between the PC generator (p1) and the
//   instruction memory bus. Issues one outstanding read per fetch address,
//   returns the word to p2, bubbles p2 when nothing valid is available,
//   drops wrong-path responses after a p3 jump, and parks one response in a
//   hold register when it arrives during a pipeline stall.
//
// Ports
//   clock, reset         : clock; synchronous active-high reset
//   stall                : global pipeline stall
//   p3_jump              : taken branch/jump in p3, flushes the wrong path
//   p1_pc                : fetch address from the PC generator (combinational)
//   imem_req/addr        : read request (combinational) and its address
//   imem_ack             : memory accepts the request this cycle
//   imem_rvalid/rdata    : in-order read response
//   p2_instr             : instruction for p2 (NOP when bubbling)
//   p2_pipeline_bubble   : no valid instruction in p2 this cycle
//   ifetch_misaligned    : registered pulse, accepted request had addr[1:0]!=0
//   ifetch_fault         : sticky response timeout, cleared only by reset
module cpu_ifetch
  import cpu_ifetch_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        p3_jump,
  input  logic [31:0] p1_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] p2_instr,
  output logic        p2_pipeline_bubble,
  output logic        ifetch_misaligned,
  output logic        ifetch_fault
);

  localparam int              CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]   TMO_MAX  = CW'(TIMEOUT_CYCLES);
  // The count is compared before its increment, so the fault fires on the
  // edge that would take it to TIMEOUT_CYCLES.
  localparam logic [CW-1:0]   TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  ifetch_state_e r_state;
  logic          r_hold_valid;
  logic [31:0]   r_hold_data;
  logic [CW-1:0] r_tmo_cnt;
  logic          r_fault;
  logic          r_misaligned;

  logic w_pending;
  logic w_resp_now;
  logic w_p2_valid;
  logic w_req;
  logic w_accept;
  logic w_timeout;

  assign w_pending  = (r_state == IFETCH_WAIT) || (r_state == IFETCH_DISCARD);
  // Only a response to a live request counts; DISCARD responses are dropped.
  assign w_resp_now = (r_state == IFETCH_WAIT) && imem_rvalid;
  assign w_p2_valid = r_hold_valid || w_resp_now;

  // A new request may overlap the cycle its predecessor returns, but never
  // while a held word is still waiting to be consumed.
  assign w_req = !reset && !stall && !r_hold_valid &&
                 ((r_state == IFETCH_IDLE) || w_resp_now);
  assign w_accept = w_req && imem_ack;

  // A response arriving on the last allowed cycle still wins over the timeout.
  assign w_timeout = w_pending && !imem_rvalid && (r_tmo_cnt == TMO_LAST);

  assign imem_req           = w_req;
  assign imem_addr          = p1_pc;
  assign p2_instr           = r_hold_valid ? r_hold_data :
                              (w_resp_now ? imem_rdata : NOP_INSTR);
  assign p2_pipeline_bubble = !w_p2_valid || reset;
  assign ifetch_misaligned  = r_misaligned;
  assign ifetch_fault       = r_fault;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IFETCH_IDLE;
      r_hold_valid <= 1'b0;
      r_hold_data  <= 32'h0;
      r_tmo_cnt    <= '0;
      r_fault      <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      r_misaligned <= w_accept && (p1_pc[1:0] != 2'b00);

      if (w_timeout) begin
        r_fault   <= 1'b1;
        r_state   <= IFETCH_IDLE;
        r_tmo_cnt <= '0;
      end else begin
        case (r_state)
          IFETCH_IDLE: begin
            if (w_accept) begin
              r_state   <= IFETCH_WAIT;
              r_tmo_cnt <= '0;
            end
          end
          IFETCH_WAIT: begin
            if (imem_rvalid) begin
              // Back-to-back: the next request was accepted alongside the
              // response, so a fresh wait begins.
              r_state   <= w_accept ? IFETCH_WAIT : IFETCH_IDLE;
              r_tmo_cnt <= '0;
            end else begin
              if (p3_jump) r_state <= IFETCH_DISCARD;
              if (r_tmo_cnt != TMO_MAX) r_tmo_cnt <= r_tmo_cnt + CW'(1);
            end
          end
          IFETCH_DISCARD: begin
            if (imem_rvalid) begin
              r_state   <= IFETCH_IDLE;
              r_tmo_cnt <= '0;
            end else if (r_tmo_cnt != TMO_MAX) begin
              r_tmo_cnt <= r_tmo_cnt + CW'(1);
            end
          end
          default: begin
            r_state   <= IFETCH_IDLE;
            r_tmo_cnt <= '0;
          end
        endcase
      end

      // Hold register: a flush or any unstalled edge consumes/kills the held
      // word; a flush also prevents capture of a response in its cycle.
      if (p3_jump || !stall) begin
        r_hold_valid <= 1'b0;
      end else if (w_resp_now) begin
        r_hold_valid <= 1'b1;
        r_hold_data  <= imem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_cpu_ifetch.sv
module tb_cpu_ifetch;

  localparam int TMO = 8;

  logic        clock = 1'b0;
  logic        reset, stall, p3_jump, imem_ack, imem_rvalid;
  logic        imem_req, p2_pipeline_bubble, ifetch_misaligned, ifetch_fault;
  logic [31:0] p1_pc, imem_addr, imem_rdata, p2_instr;

  always #5 clock = ~clock;

  cpu_ifetch #(.TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset), .stall(stall), .p3_jump(p3_jump),
    .p1_pc(p1_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .p2_instr(p2_instr), .p2_pipeline_bubble(p2_pipeline_bubble),
    .ifetch_misaligned(ifetch_misaligned), .ifetch_fault(ifetch_fault)
  );

  int n_cmp = 0;
  int n_err = 0;

  // environment: PC generator + single-outstanding memory
  logic [31:0] pc, jump_tgt, mem_a, force_val;
  bit          force_on, dead, lat_rand, mem_pend;
  int          lat, mem_cnt;

  // reference model: "is a request outstanding, was it flushed, is a word held"
  bit          m_out, m_kill, m_hv, m_fault, m_mis;
  logic [31:0] m_hd;
  int          m_wait;

  // per-cycle values shared between the two halves of a cycle
  bit          t_rv, t_resp, t_acc_dut, t_acc_m;
  logic [31:0] t_addr;
  logic        e_req, e_bub;
  logic [31:0] e_instr;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[31:16]} + a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // First half: drive env inputs, predict, compare (inputs set at negedge).
  task automatic tick_a();
    if (p3_jump) pc = jump_tgt;
    p1_pc = pc;
    t_rv = mem_pend && (mem_cnt == 0) && !dead;
    imem_rvalid = t_rv;
    imem_rdata  = t_rv ? (force_on ? force_val : memword(mem_a)) : $urandom();
    t_resp  = m_out && !m_kill && t_rv;
    e_req   = !reset && !stall && !m_hv && (!m_out || t_resp);
    e_bub   = reset || !(m_hv || t_resp);
    e_instr = m_hv ? m_hd : (t_resp ? imem_rdata : 32'h0);
    #1;
    chk1("p2_pipeline_bubble", p2_pipeline_bubble, e_bub);
    chk1("imem_req", imem_req, e_req);
    chk("imem_addr", imem_addr, p1_pc);
    chk("p2_instr", p2_instr, e_instr);
    chk1("ifetch_misaligned", ifetch_misaligned, m_mis);
    chk1("ifetch_fault", ifetch_fault, m_fault);
    t_acc_dut = imem_req && imem_ack;
    t_acc_m   = e_req && imem_ack;
    t_addr    = imem_addr;
  endtask

  // Second half: clock edge, then advance model and environment.
  task automatic tick_b();
    @(posedge clock);
    if (reset) begin
      m_out = 0; m_kill = 0; m_hv = 0; m_hd = 32'h0; m_wait = 0; m_fault = 0; m_mis = 0;
    end else begin
      m_mis = t_acc_m && (pc[1:0] != 2'b00);
      if (m_out && t_rv) begin
        m_out = t_acc_m; m_kill = 0; m_wait = 0;
      end else if (m_out) begin
        if (p3_jump) m_kill = 1;
        m_wait++;
        if (m_wait >= TMO) begin
          m_fault = 1; m_out = 0; m_kill = 0; m_wait = 0;
        end
      end else if (t_acc_m) begin
        m_out = 1; m_wait = 0;
      end
      if (p3_jump || !stall) m_hv = 0;
      else if (t_resp) begin
        m_hv = 1; m_hd = imem_rdata;
      end
    end
    if (t_rv) mem_pend = 0;
    else if (mem_pend && mem_cnt > 0) mem_cnt--;
    if (t_acc_dut) begin
      mem_pend = 1;
      mem_a    = t_addr;
      mem_cnt  = lat_rand ? int'($urandom_range(3, 0)) : lat;
      pc       = pc + 32'd4;
    end
    @(negedge clock);
  endtask

  task automatic cycle();
    tick_a();
    tick_b();
  endtask

  // Let any outstanding fetch complete with no new requests accepted.
  task automatic drain();
    int i;
    imem_ack = 0; stall = 0; p3_jump = 0; reset = 0;
    i = 0;
    while ((m_out || mem_pend) && i < 20) begin
      cycle();
      i++;
    end
    chk1("drain_bound", m_out || mem_pend, 1'b0);
  endtask

  initial begin
    reset = 1; stall = 0; p3_jump = 0; imem_ack = 0; imem_rvalid = 0;
    imem_rdata = 32'h0; p1_pc = 32'h0; pc = 32'h0; jump_tgt = 32'h0;
    force_on = 0; force_val = 32'h0; dead = 0; lat_rand = 0; lat = 0;
    mem_pend = 0; mem_cnt = 0; mem_a = 32'h0;
    m_out = 0; m_kill = 0; m_hv = 0; m_hd = 32'h0; m_wait = 0; m_fault = 0; m_mis = 0;
    @(posedge clock);
    @(negedge clock);

    // reset state
    tick_a();
    chk1("rst_bubble", p2_pipeline_bubble, 1'b1);
    chk1("rst_req", imem_req, 1'b0);
    chk1("rst_fault", ifetch_fault, 1'b0);
    tick_b();
    reset = 0;

    // zero-wait memory, sequential from FFFF0000
    pc = 32'hFFFF_0000; imem_ack = 1; lat = 0;
    for (int i = 0; i < 8; i++) begin
      tick_a();
      if (i > 0) begin
        chk1("zw_bubble", p2_pipeline_bubble, 1'b0);
        chk("zw_instr", p2_instr, memword(32'hFFFF_0000 + 32'(4 * (i - 1))));
      end
      tick_b();
    end
    drain();

    // three extra memory wait cycles
    imem_ack = 1; lat = 3;
    begin
      logic [31:0] a0;
      a0 = pc;
      cycle();
      for (int i = 0; i < 3; i++) begin
        tick_a();
        chk1("dly_bubble", p2_pipeline_bubble, 1'b1);
        chk1("dly_req", imem_req, 1'b0);
        tick_b();
      end
      tick_a();
      chk1("dly_arrive_bubble", p2_pipeline_bubble, 1'b0);
      chk("dly_arrive_instr", p2_instr, memword(a0));
      tick_b();
    end
    drain();

    // jump while waiting: late DEADBEEF response is dropped
    imem_ack = 1; lat = 2; force_on = 1; force_val = 32'hDEAD_BEEF;
    cycle();
    p3_jump = 1; jump_tgt = 32'h0000_1000;
    tick_a();
    chk1("drop_bubble", p2_pipeline_bubble, 1'b1);
    tick_b();
    p3_jump = 0;
    for (int i = 0; i < 2; i++) begin
      tick_a();
      chk1("drop_bubble", p2_pipeline_bubble, 1'b1);
      chk("drop_instr", p2_instr, 32'h0);
      tick_b();
    end
    force_on = 0;
    tick_a();
    chk1("jump_req", imem_req, 1'b1);
    chk("jump_addr", imem_addr, 32'h0000_1000);
    tick_b();
    drain();

    // response during a 2-cycle stall goes to the hold register
    imem_ack = 1; lat = 0; force_on = 1; force_val = 32'h1234_5678;
    cycle();
    stall = 1;
    for (int i = 0; i < 2; i++) begin
      tick_a();
      chk("hold_instr", p2_instr, 32'h1234_5678);
      chk1("hold_bubble", p2_pipeline_bubble, 1'b0);
      chk1("hold_req", imem_req, 1'b0);
      tick_b();
    end
    stall = 0;
    tick_a();
    chk("hold_release_instr", p2_instr, 32'h1234_5678);
    chk1("hold_release_req", imem_req, 1'b0);
    tick_b();
    force_on = 0;
    tick_a();
    chk1("hold_cleared_bubble", p2_pipeline_bubble, 1'b1);
    chk1("hold_cleared_req", imem_req, 1'b1);
    tick_b();
    drain();

    // reset mid-WAIT, stale response afterwards
    imem_ack = 1; lat = 1;
    cycle();
    reset = 1;
    cycle();
    reset = 0;
    tick_a();
    chk1("stale_bubble", p2_pipeline_bubble, 1'b1);
    chk("stale_instr", p2_instr, 32'h0);
    chk1("stale_req", imem_req, 1'b1);
    chk("stale_addr", imem_addr, pc);
    tick_b();
    drain();

    // memory never answers: timeout after TMO waiting cycles
    dead = 1; imem_ack = 1; lat = 0;
    cycle();
    for (int i = 0; i < TMO; i++) begin
      tick_a();
      chk1("tmo_early", ifetch_fault, 1'b0);
      tick_b();
    end
    tick_a();
    chk1("tmo_fault", ifetch_fault, 1'b1);
    chk1("tmo_idle_req", imem_req, 1'b1);
    tick_b();
    for (int i = 0; i < 20; i++) cycle();
    tick_a();
    chk1("tmo_sticky", ifetch_fault, 1'b1);
    tick_b();
    reset = 1;
    cycle();
    reset = 0; dead = 0; mem_pend = 0;
    tick_a();
    chk1("tmo_cleared", ifetch_fault, 1'b0);
    chk1("tmo_cleared_req", imem_req, 1'b1);
    tick_b();
    drain();

    // randomized traffic
    lat_rand = 1;
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(199, 0) == 0);
      stall    = ($urandom_range(99, 0) < 25);
      p3_jump  = ($urandom_range(99, 0) < 8);
      imem_ack = ($urandom_range(99, 0) < 80);
      jump_tgt = $urandom();
      if ($urandom_range(9, 0) != 0) jump_tgt[1:0] = 2'b00;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
